// File: rtl/dmem_block_store_pkg.sv
// Shared definitions for the block data memory and the cache that talks to it.
package dmem_block_store_pkg;

  // Width of one cache block (4 x 32-bit words); the cache imports the same value.
  localparam int BLOCK_W = 128;

  // Width of the block address presented by the cache.
  localparam int ADDR_W = 30;

  // Memory controller states.
  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_BUSY = 2'd1,
    DM_DONE = 2'd2
  } dm_state_t;

  // Operation latched at the start of an access.
  typedef enum logic {
    DM_OP_READ  = 1'b0,
    DM_OP_WRITE = 1'b1
  } dm_op_t;

endpackage

// File: rtl/dmem_block_store_if.sv
// Block-transfer bus between the data cache (master) and main data memory (slave).
interface dmem_block_store_if;
  import dmem_block_store_pkg::*;

  logic               MEM_READ;
  logic               MEM_WRITE;
  logic [ADDR_W-1:0]  MEM_BLOCK_ADDR;
  logic [BLOCK_W-1:0] MEM_WRITE_DATA;
  logic [BLOCK_W-1:0] MEM_READ_DATA;
  logic               MEM_BUSYWAIT;

  // Cache side: issues requests, receives refill data and the stall.
  modport master (
    output MEM_READ,
    output MEM_WRITE,
    output MEM_BLOCK_ADDR,
    output MEM_WRITE_DATA,
    input  MEM_READ_DATA,
    input  MEM_BUSYWAIT
  );

  // Memory side: accepts requests, returns refill data and the stall.
  modport slave (
    input  MEM_READ,
    input  MEM_WRITE,
    input  MEM_BLOCK_ADDR,
    input  MEM_WRITE_DATA,
    output MEM_READ_DATA,
    output MEM_BUSYWAIT
  );

endinterface

// File: rtl/dmem_block_store_array.sv
// Synchronous single-port block RAM with registered read; read-during-write returns old data.
module dmem_array
  import dmem_block_store_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int W          = BLOCK_W
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [W-1:0]          wdata,
  output logic [W-1:0]          rdata
);

  logic [W-1:0] r_mem [2**DEPTH_LOG2];

  // Write port and registered read port share one address; no reset on storage.
  always_ff @(posedge CLK) begin
    if (we) begin
      r_mem[idx] <= wdata;
    end
    rdata <= r_mem[idx];
  end

endmodule

// File: rtl/dmem_block_store.sv
// Main data memory: whole-block refills and write-backs with a fixed multi-cycle latency.
module dmem_block_store
  import dmem_block_store_pkg::*;
#(
  parameter int ACCESS_CYCLES = 5,
  parameter int DEPTH_LOG2    = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  dmem_block_store_if.slave  bus
);

  // Counter holds the remaining BUSY cycles after the start cycle.
  localparam int CW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES - 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 2);

  dm_state_t             r_state, w_state_next;
  logic [CW-1:0]         r_cnt, w_cnt_next;
  dm_op_t                r_op, w_op_next;
  logic [DEPTH_LOG2-1:0] r_idx, w_idx_next;
  logic [BLOCK_W-1:0]    r_wdata, w_wdata_next;
  logic [BLOCK_W-1:0]    r_read_data;
  logic [BLOCK_W-1:0]    w_ram_rdata;
  logic                  w_busywait;
  logic                  w_commit;
  logic                  w_ram_we;

  // Address bits above the array index alias onto the same blocks.
  logic w_unused_addr;
  assign w_unused_addr = ^bus.MEM_BLOCK_ADDR[ADDR_W-1:DEPTH_LOG2];

  // State and counter register; reset returns to IDLE and abandons any access.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= DM_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Request latches: captured in IDLE, held unchanged through BUSY.
  always_ff @(posedge CLK) begin
    r_op    <= w_op_next;
    r_idx   <= w_idx_next;
    r_wdata <= w_wdata_next;
  end

  // Next-state, stall and commit decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_op_next    = r_op;
    w_idx_next   = r_idx;
    w_wdata_next = r_wdata;
    w_busywait   = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      DM_IDLE: begin
        // Busy is raised in the request cycle so the cache stalls on its first edge.
        w_busywait = bus.MEM_READ | bus.MEM_WRITE;
        if (bus.MEM_READ || bus.MEM_WRITE) begin
          w_state_next = DM_BUSY;
          w_op_next    = bus.MEM_READ ? DM_OP_READ : DM_OP_WRITE;
          w_idx_next   = bus.MEM_BLOCK_ADDR[DEPTH_LOG2-1:0];
          w_wdata_next = bus.MEM_WRITE_DATA;
          w_cnt_next   = CNT_LOAD;
        end
      end
      DM_BUSY: begin
        w_busywait = 1'b1;
        if (r_cnt == '0) begin
          w_commit     = 1'b1;
          w_state_next = DM_DONE;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      DM_DONE: begin
        // A still-asserted request is only picked up again once back in IDLE.
        w_state_next = DM_IDLE;
      end
      default: begin
        w_state_next = DM_IDLE;
      end
    endcase
  end

  // A write commits only if reset is not aborting the access on the same edge.
  assign w_ram_we = w_commit && (r_op == DM_OP_WRITE) && RESET;

  // RAM address follows the next index, so the read launched at the request edge is
  // already valid in BUSY; this works for the minimum two-cycle access too.
  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .W          (BLOCK_W)
  ) u_array (
    .CLK   (CLK),
    .we    (w_ram_we),
    .idx   (w_idx_next),
    .wdata (r_wdata),
    .rdata (w_ram_rdata)
  );

  // Refill output register: loads only on a read commit, cleared by reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_read_data <= '0;
    end else if (w_commit && (r_op == DM_OP_READ)) begin
      r_read_data <= w_ram_rdata;
    end
  end

  assign bus.MEM_READ_DATA = r_read_data;
  assign bus.MEM_BUSYWAIT  = w_busywait;

endmodule

// File: tb/tb_dmem_block_store.sv
// Directed bench for dmem_block_store with hand-computed expected values.
module tb_dmem_block_store;
  import dmem_block_store_pkg::*;

  localparam logic [127:0] PAT_A  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] PAT_B  = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [127:0] PAT_X  = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] PAT_Y  = 128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0001;
  localparam logic [127:0] PAT_C  = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
  localparam logic [127:0] ONES   = {128{1'b1}};
  localparam logic [127:0] ZERO   = '0;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  dmem_block_store_if bus();

  dmem_block_store #(
    .ACCESS_CYCLES (5),
    .DEPTH_LOG2    (8)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // One access; returns busy-cycle count and read data sampled in the DONE cycle.
  task automatic access(input bit rd, input bit wr, input logic [29:0] addr,
                        input logic [127:0] data, output int busy, output logic [127:0] rdat);
    @(negedge clk);
    bus.MEM_READ       = rd;
    bus.MEM_WRITE      = wr;
    bus.MEM_BLOCK_ADDR = addr;
    bus.MEM_WRITE_DATA = data;
    busy = 0;
    #1;
    while (bus.MEM_BUSYWAIT === 1'b1 && busy < 20) begin
      busy++;
      @(negedge clk);
      #1;
    end
    rdat = bus.MEM_READ_DATA;
    bus.MEM_READ  = 1'b0;
    bus.MEM_WRITE = 1'b0;
  endtask

  initial begin
    int           busy;
    logic [127:0] rdat;
    logic [11:0]  pat;

    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    bus.MEM_READ       = 1'b0;
    bus.MEM_WRITE      = 1'b0;
    bus.MEM_BLOCK_ADDR = '0;
    bus.MEM_WRITE_DATA = '0;

    // 1. Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rdata", bus.MEM_READ_DATA, ZERO);
    chk("reset_busy", {127'd0, bus.MEM_BUSYWAIT}, ZERO);
    rst_n = 1'b1;

    // Establish known zero contents for blocks used below.
    access(0, 1, 30'h10, ZERO, busy, rdat);
    access(0, 1, 30'h22, ZERO, busy, rdat);

    // 2. Write then read the same block.
    access(0, 1, 30'h05, PAT_A, busy, rdat);
    chk("wr05_busy", 128'(busy), 128'd5);
    access(1, 0, 30'h05, ZERO, busy, rdat);
    chk("rd05_busy", 128'(busy), 128'd5);
    chk("rd05_data", rdat, PAT_A);

    // 3. Read and write together: read wins, write dropped.
    access(1, 1, 30'h10, ONES, busy, rdat);
    chk("rdwr10_busy", 128'(busy), 128'd5);
    chk("rdwr10_data", rdat, ZERO);
    access(1, 0, 30'h10, ZERO, busy, rdat);
    chk("rd10_after", rdat, ZERO);

    // Writes never disturb the refill register.
    access(1, 0, 30'h05, ZERO, busy, rdat);
    chk("rd05_again", rdat, PAT_A);
    access(0, 1, 30'h06, PAT_B, busy, rdat);
    chk("hold_after_wr", bus.MEM_READ_DATA, PAT_A);

    // 4. Reset in the 3rd BUSY cycle of a write aborts it.
    @(negedge clk);
    bus.MEM_WRITE      = 1'b1;
    bus.MEM_BLOCK_ADDR = 30'h22;
    bus.MEM_WRITE_DATA = ONES;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    bus.MEM_WRITE = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("abort_rdata", bus.MEM_READ_DATA, ZERO);
    chk("abort_busy", {127'd0, bus.MEM_BUSYWAIT}, ZERO);
    access(1, 0, 30'h22, ZERO, busy, rdat);
    chk("rd22_prior", rdat, ZERO);

    // 5. Aliasing: 0x100 lands on block 0x000.
    access(0, 1, 30'h100, PAT_C, busy, rdat);
    access(1, 0, 30'h000, ZERO, busy, rdat);
    chk("alias_000", rdat, PAT_C);

    // Request dropped and inputs changed mid-BUSY: latched access still commits.
    @(negedge clk);
    bus.MEM_WRITE      = 1'b1;
    bus.MEM_BLOCK_ADDR = 30'h33;
    bus.MEM_WRITE_DATA = PAT_B;
    @(negedge clk);
    bus.MEM_WRITE      = 1'b0;
    bus.MEM_BLOCK_ADDR = 30'h34;
    bus.MEM_WRITE_DATA = ONES;
    repeat (5) @(negedge clk);
    access(1, 0, 30'h33, ZERO, busy, rdat);
    chk("nocancel_33", rdat, PAT_B);

    // 6. Back-to-back: write held high through DONE.
    @(negedge clk);
    bus.MEM_WRITE      = 1'b1;
    bus.MEM_BLOCK_ADDR = 30'h40;
    bus.MEM_WRITE_DATA = PAT_X;
    pat = '0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 2) begin
        bus.MEM_WRITE_DATA = ONES;
        bus.MEM_BLOCK_ADDR = 30'h41;
      end
      if (i == 5) begin
        bus.MEM_WRITE_DATA = PAT_Y;
        bus.MEM_BLOCK_ADDR = 30'h41;
      end
      if (i == 8) bus.MEM_WRITE_DATA = ONES;
      #1;
      pat[i] = bus.MEM_BUSYWAIT;
    end
    bus.MEM_WRITE = 1'b0;
    chk("b2b_busy_pattern", {116'd0, pat}, {116'd0, 12'b0111_1101_1111});
    access(1, 0, 30'h40, ZERO, busy, rdat);
    chk("b2b_rd40", rdat, PAT_X);
    access(1, 0, 30'h41, ZERO, busy, rdat);
    chk("b2b_rd41", rdat, PAT_Y);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
